frame_config_writer: RTL and testbench

FRAME_CONFIG_WRITER -- requirements
Module: frame_config_writer

---
 rtl/frame_cfg_pkg.sv | 20 ++
 rtl/frame_strobe_decoder.sv | 28 ++
 rtl/frame_config_writer.sv | 133 +++++++++++++
 tb/tb_frame_config_writer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_cfg_pkg.sv
// Shared types and header layout for the frame configuration writer.
package frame_cfg_pkg;

  // Writer FSM states; ready is offered only in StIdle and StLoad.
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSetup,
    StStrobe,
    StHold
  } cfg_state_e;

  // Header word layout: [31:24] sync, [15:8] frame index, [7:0] column index.
  localparam logic [7:0]  SYNC_BYTE   = 8'hFB;
  localparam int unsigned HdrFieldW   = 8;
  localparam int unsigned HdrSyncLsb  = 24;
  localparam int unsigned HdrFrameLsb = 8;
  localparam int unsigned HdrColLsb   = 0;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Maps a (column, frame) address to the one-hot column-major strobe vector.
module frame_strobe_decoder #(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned NumCols         = 4,
  parameter int unsigned ColW            = 2,
  parameter int unsigned FrameW          = 5
) (
  input  logic [ColW-1:0]                       column,
  input  logic [FrameW-1:0]                     frame,
  input  logic                                  enable,
  output logic [MaxFramesPerCol*NumCols-1:0]    strobe
);

  // One bit at column*MaxFramesPerCol+frame when enabled, all-zero otherwise.
  always_comb begin
    strobe = '0;
    if (enable) begin
      for (int c = 0; c < NumCols; c++) begin
        for (int f = 0; f < MaxFramesPerCol; f++) begin
          if (column == ColW'(c) && frame == FrameW'(f)) begin
            strobe[c*MaxFramesPerCol+f] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/frame_config_writer.sv
// Accepts a header plus NumRows data words from the host, then writes one
// configuration frame by pulsing a single registered FrameStrobe bit.
module frame_config_writer
  import frame_cfg_pkg::*;
#(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned NumRows         = 4,
  parameter int unsigned NumCols         = 4
) (
  input  logic                                    UserCLK,
  input  logic                                    resetn,
  input  logic                                    cfg_valid,
  output logic                                    cfg_ready,
  input  logic [31:0]                             cfg_data,
  output logic [FrameBitsPerRow*NumRows-1:0]      FrameData,
  output logic [MaxFramesPerCol*NumCols-1:0]      FrameStrobe,
  output logic                                    cfg_done,
  output logic                                    cfg_err
);

  localparam int unsigned ColW   = (NumCols > 1) ? $clog2(NumCols) : 1;
  localparam int unsigned FrameW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
  localparam int unsigned RowW   = (NumRows > 1) ? $clog2(NumRows) : 1;

  cfg_state_e        state_q;
  logic [RowW-1:0]   row_q;
  logic [ColW-1:0]   col_q;
  logic [FrameW-1:0] frame_q;

  logic [HdrFieldW-1:0] hdr_sync;
  logic [HdrFieldW-1:0] hdr_frame;
  logic [HdrFieldW-1:0] hdr_col;
  logic                 hdr_ok;
  logic                 xfer;
  logic                 unused_hdr_rsvd;
  logic [MaxFramesPerCol*NumCols-1:0] strobe_next;

  // Header field extraction and range check.
  always_comb begin
    hdr_sync  = cfg_data[HdrSyncLsb +: HdrFieldW];
    hdr_frame = cfg_data[HdrFrameLsb +: HdrFieldW];
    hdr_col   = cfg_data[HdrColLsb +: HdrFieldW];
    hdr_ok    = (hdr_sync == SYNC_BYTE) &&
                (32'(hdr_frame) < MaxFramesPerCol) &&
                (32'(hdr_col) < NumCols);
  end

  // Header bits [23:16] are reserved and ignored.
  assign unused_hdr_rsvd = ^cfg_data[23:16];

  assign cfg_ready = (state_q == StIdle) || (state_q == StLoad);
  assign xfer      = cfg_valid && cfg_ready;

  // Strobe pattern is computed during SETUP and registered into STROBE.
  frame_strobe_decoder #(
    .MaxFramesPerCol (MaxFramesPerCol),
    .NumCols         (NumCols),
    .ColW            (ColW),
    .FrameW          (FrameW)
  ) u_strobe_decoder (
    .column (col_q),
    .frame  (frame_q),
    .enable (state_q == StSetup),
    .strobe (strobe_next)
  );

  // Writer FSM with registered FrameData, FrameStrobe, cfg_done and cfg_err.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      frame_q     <= '0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      cfg_done    <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (xfer) begin
            if (hdr_ok) begin
              col_q   <= hdr_col[ColW-1:0];
              frame_q <= hdr_frame[FrameW-1:0];
              row_q   <= '0;
              state_q <= StLoad;
            end else begin
              // Rejected header is consumed; the error stays until reset.
              cfg_err <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (xfer) begin
            for (int r = 0; r < NumRows; r++) begin
              if (row_q == RowW'(r)) begin
                FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <=
                    cfg_data[FrameBitsPerRow-1:0];
              end
            end
            if (row_q == RowW'(NumRows - 1)) begin
              row_q   <= '0;
              state_q <= StSetup;
            end else begin
              row_q <= row_q + RowW'(1);
            end
          end
        end
        StSetup: begin
          // FrameData has now been stable for a full cycle.
          FrameStrobe <= strobe_next;
          state_q     <= StStrobe;
        end
        StStrobe: begin
          FrameStrobe <= '0;
          cfg_done    <= 1'b1;
          state_q     <= StHold;
        end
        StHold: begin
          cfg_done <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          FrameStrobe <= '0;
          cfg_done    <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_config_writer.sv
// Directed self-checking bench for frame_config_writer (default parameters).
module tb_frame_config_writer;

  localparam int M  = 20;
  localparam int FB = 32;
  localparam int NR = 4;
  localparam int NC = 4;
  localparam int DW = FB * NR;
  localparam int SW = M * NC;

  logic          UserCLK = 1'b0;
  logic          resetn  = 1'b1;
  logic          cfg_valid = 1'b0;
  logic [31:0]   cfg_data  = '0;
  logic          cfg_ready;
  logic [DW-1:0] FrameData;
  logic [SW-1:0] FrameStrobe;
  logic          cfg_done;
  logic          cfg_err;

  int vectors    = 0;
  int miscompares = 0;

  frame_config_writer #(
    .MaxFramesPerCol (M),
    .FrameBitsPerRow (FB),
    .NumRows         (NR),
    .NumCols         (NC)
  ) dut (
    .UserCLK     (UserCLK),
    .resetn      (resetn),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_data    (cfg_data),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err)
  );

  always #5 UserCLK = ~UserCLK;

  // Drive one word and hold it until it transfers; returns #1 after that edge.
  task automatic put_word(input logic [31:0] w, input string name);
    int n;
    n = 0;
    @(negedge UserCLK);
    cfg_valid = 1'b1;
    cfg_data  = w;
    while (cfg_ready !== 1'b1 && n < 50) begin
      @(negedge UserCLK);
      n++;
    end
    vectors++;
    if (cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ready: cfg_ready=%b, required 1", name, cfg_ready);
    end
    @(posedge UserCLK);
    #1;
  endtask

  // Header plus NR data words; gaps>0 inserts gaps*(row+1) idle cycles after each row.
  task automatic send_frame(input logic [31:0] hdr, input logic [DW-1:0] data,
                            input int gaps, input string name);
    logic [31:0] w;
    put_word(hdr, name);
    for (int r = 0; r < NR; r++) begin
      w = data[r*FB +: FB];
      put_word(w, name);
      vectors++;
      if (FrameData[r*FB +: FB] !== w) begin
        miscompares++;
        $display("FAIL %s_row%0d: FrameData row=%h, required %h", name, r,
                 FrameData[r*FB +: FB], w);
      end
      if (gaps > 0 && r < NR - 1) begin
        cfg_valid = 1'b0;
        repeat (gaps * (r + 1)) begin
          @(posedge UserCLK);
          #1;
          vectors++;
          if (cfg_ready !== 1'b1 || FrameStrobe !== '0) begin
            miscompares++;
            $display("FAIL %s_stall: ready=%b strobe=%h, required ready=1 strobe=0",
                     name, cfg_ready, FrameStrobe);
          end
        end
      end
    end
  endtask

  // Checks SETUP/STROBE/HOLD/IDLE timing after the last data word.
  task automatic check_frame(input string name, input int col, input int frm,
                             input logic [DW-1:0] exp_data);
    logic [SW-1:0] exp_strobe;
    exp_strobe = '0;
    exp_strobe[col*M+frm] = 1'b1;
    cfg_valid = 1'b0;
    // t+1: SETUP
    vectors++;
    if (FrameStrobe !== '0 || cfg_ready !== 1'b0 || cfg_done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_setup: strobe=%h ready=%b done=%b, required 0/0/0",
               name, FrameStrobe, cfg_ready, cfg_done);
    end
    vectors++;
    if (FrameData !== exp_data) begin
      miscompares++;
      $display("FAIL %s_data: FrameData=%h, required %h", name, FrameData, exp_data);
    end
    // t+2: STROBE
    @(posedge UserCLK);
    #1;
    vectors++;
    if (FrameStrobe !== exp_strobe || cfg_done !== 1'b0 || cfg_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_strobe: strobe=%h done=%b ready=%b, required %h/0/0",
               name, FrameStrobe, cfg_done, cfg_ready, exp_strobe);
    end
    // t+3: HOLD
    @(posedge UserCLK);
    #1;
    vectors++;
    if (FrameStrobe !== '0 || cfg_done !== 1'b1 || cfg_ready !== 1'b0 ||
        FrameData !== exp_data) begin
      miscompares++;
      $display("FAIL %s_hold: strobe=%h done=%b ready=%b data=%h, required 0/1/0/%h",
               name, FrameStrobe, cfg_done, cfg_ready, FrameData, exp_data);
    end
    // t+4: IDLE
    @(posedge UserCLK);
    #1;
    vectors++;
    if (FrameStrobe !== '0 || cfg_done !== 1'b0 || cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_idle: strobe=%h done=%b ready=%b, required 0/0/1",
               name, FrameStrobe, cfg_done, cfg_ready);
    end
  endtask

  task automatic apply_reset();
    cfg_valid = 1'b0;
    resetn = 1'b0;
    #1;
    @(negedge UserCLK);
    resetn = 1'b1;
  endtask

  task automatic check_idle_after_reject(input string name, input logic [DW-1:0] exp_data);
    cfg_valid = 1'b0;
    vectors++;
    if (cfg_err !== 1'b1 || cfg_ready !== 1'b1 || FrameStrobe !== '0 ||
        FrameData !== exp_data) begin
      miscompares++;
      $display("FAIL %s: err=%b ready=%b strobe=%h data=%h, required 1/1/0/%h",
               name, cfg_err, cfg_ready, FrameStrobe, FrameData, exp_data);
    end
    repeat (3) @(posedge UserCLK);
    #1;
    vectors++;
    if (FrameStrobe !== '0 || cfg_done !== 1'b0 || cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_quiet: strobe=%h done=%b ready=%b, required 0/0/1",
               name, FrameStrobe, cfg_done, cfg_ready);
    end
  endtask

  task automatic test_reset();
    #2;
    resetn = 1'b0;
    #1;
    vectors++;
    if (FrameData !== '0 || FrameStrobe !== '0 || cfg_done !== 1'b0 || cfg_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: data=%h strobe=%h done=%b err=%b, required all 0",
               FrameData, FrameStrobe, cfg_done, cfg_err);
    end
    repeat (2) @(negedge UserCLK);
    resetn = 1'b1;
    @(posedge UserCLK);
    #1;
    vectors++;
    if (cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: cfg_ready=%b, required 1", cfg_ready);
    end
  endtask

  task automatic test_basic();
    send_frame(32'hFB000201, 128'h44444444_33333333_22222222_11111111, 0, "basic");
    check_frame("basic", 1, 2, 128'h44444444_33333333_22222222_11111111);
  endtask

  task automatic test_bad_sync();
    put_word(32'hFA000000, "badsync");
    check_idle_after_reject("badsync", 128'h44444444_33333333_22222222_11111111);
    send_frame(32'hFB000000, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 0, "aftererr");
    check_frame("aftererr", 0, 0, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    vectors++;
    if (cfg_err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: cfg_err=%b, required 1", cfg_err);
    end
  endtask

  task automatic test_bad_range();
    apply_reset();
    put_word(32'hFB001400, "badframe");
    check_idle_after_reject("badframe", '0);
    apply_reset();
    put_word(32'hFB000004, "badcol");
    check_idle_after_reject("badcol", '0);
  endtask

  task automatic test_stall();
    send_frame(32'hFB000502, 128'h0BADF00D_CAFEBABE_12345678_DEADBEEF, 1, "stall");
    check_frame("stall", 2, 5, 128'h0BADF00D_CAFEBABE_12345678_DEADBEEF);
  endtask

  task automatic test_reset_mid();
    logic [SW-1:0] exp_strobe;
    put_word(32'hFB000301, "midload");
    put_word(32'h01010101, "midload");
    put_word(32'h02020202, "midload");
    cfg_valid = 1'b0;
    resetn = 1'b0;
    #1;
    vectors++;
    if (FrameData !== '0 || FrameStrobe !== '0 || cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midload_reset: data=%h strobe=%h ready=%b, required 0/0/1",
               FrameData, FrameStrobe, cfg_ready);
    end
    @(negedge UserCLK);
    resetn = 1'b1;
    send_frame(32'hFB000301, 128'h04040404_03030303_02020202_01010101, 0, "fresh");
    check_frame("fresh", 1, 3, 128'h04040404_03030303_02020202_01010101);
    // Reset while the strobe is high must remove it in the same cycle.
    send_frame(32'hFB000A02, 128'h55555555_66666666_77777777_88888888, 0, "midstrobe");
    cfg_valid = 1'b0;
    @(posedge UserCLK);
    #1;
    exp_strobe = '0;
    exp_strobe[2*M+10] = 1'b1;
    vectors++;
    if (FrameStrobe !== exp_strobe) begin
      miscompares++;
      $display("FAIL midstrobe_pulse: strobe=%h, required %h", FrameStrobe, exp_strobe);
    end
    resetn = 1'b0;
    #1;
    vectors++;
    if (FrameStrobe !== '0 || FrameData !== '0) begin
      miscompares++;
      $display("FAIL midstrobe_reset: strobe=%h data=%h, required 0/0", FrameStrobe, FrameData);
    end
    @(negedge UserCLK);
    resetn = 1'b1;
  endtask

  task automatic test_back_to_back();
    send_frame(32'hFB001303, 128'hF0F0F0F0_0F0F0F0F_A5A5A5A5_5A5A5A5A, 0, "b2b_first");
    check_frame("b2b_first", 3, 19, 128'hF0F0F0F0_0F0F0F0F_A5A5A5A5_5A5A5A5A);
    send_frame(32'hFB000000, 128'h00000004_00000003_00000002_00000001, 0, "b2b_second");
    check_frame("b2b_second", 0, 0, 128'h00000004_00000003_00000002_00000001);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_sync();
    test_bad_range();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
